// File: rtl/axis_adc_trigger_ctrl.sv
// Armed ADC capture controller: holdoff, edge/force trigger, and fixed-length
// AXI-Stream capture through a single 1-deep output register.
module axis_adc_trigger_ctrl #(
  parameter int unsigned ADC_DATA_WIDTH = 14,
  parameter int unsigned CNTR_WIDTH     = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic                  cfg_chan,
  input  logic                  cfg_edge,
  input  logic [15:0]           cfg_level,
  input  logic [CNTR_WIDTH-1:0] cfg_holdoff,
  input  logic [CNTR_WIDTH-1:0] cfg_total,
  input  logic                  s_axis_tvalid,
  input  logic [31:0]           s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [2:0]            sts_state,
  output logic                  sts_overrun
);

  localparam int unsigned CH_W   = 16;
  // Channel lanes carry ADC_DATA_WIDTH significant bits; re-extend from that MSB.
  localparam int unsigned EXT_SH = CH_W - ADC_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLDOFF = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    chan_q, chan_d;
  logic                    edge_q, edge_d;
  logic signed [CH_W-1:0]  level_q, level_d;
  logic [CNTR_WIDTH-1:0]   holdoff_q, holdoff_d;
  logic [CNTR_WIDTH-1:0]   total_q, total_d;
  logic [CNTR_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNTR_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic signed [CH_W-1:0]  prev_q, prev_d;
  logic                    prev_vld_q, prev_vld_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [31:0]             tdata_q, tdata_d;
  logic                    overrun_q, overrun_d;

  logic [CH_W-1:0]         raw_c;
  logic [CH_W-1:0]         shl_c;
  logic signed [CH_W-1:0]  cur_c;
  logic                    edge_hit_c;
  logic                    trig_c;
  logic                    out_free_c;
  logic [CNTR_WIDTH-1:0]   hold_nxt_c;
  logic [CNTR_WIDTH-1:0]   beat_nxt_c;

  // Selected-channel sample, trigger decision and counter increments.
  always_comb begin
    raw_c      = cfg_chan_sel(chan_q, s_axis_tdata);
    shl_c      = CH_W'(raw_c << EXT_SH);
    cur_c      = $signed(shl_c) >>> EXT_SH;
    if (edge_q) begin
      edge_hit_c = (prev_q > level_q) && (cur_c <= level_q);
    end else begin
      edge_hit_c = (prev_q < level_q) && (cur_c >= level_q);
    end
    trig_c     = s_axis_tvalid && (force_trig || (prev_vld_q && edge_hit_c));
    out_free_c = !tvalid_q || m_axis_tready;
    hold_nxt_c = CNTR_WIDTH'(hold_cnt_q + 1'b1);
    beat_nxt_c = CNTR_WIDTH'(beat_cnt_q + 1'b1);
  end

  function automatic logic [CH_W-1:0] cfg_chan_sel(input logic sel, input logic [31:0] data);
    return sel ? data[31:16] : data[15:0];
  endfunction

  // Next-state, config latch, output register and status update.
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    edge_d     = edge_q;
    level_d    = level_q;
    holdoff_d  = holdoff_q;
    total_d    = total_q;
    hold_cnt_d = hold_cnt_q;
    beat_cnt_d = beat_cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    overrun_d  = overrun_q;

    // A completed handshake empties the output register unless refilled below.
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        prev_vld_d = 1'b0;
        if (arm && !abort && (cfg_total != '0)) begin
          chan_d     = cfg_chan;
          edge_d     = cfg_edge;
          level_d    = $signed(cfg_level);
          holdoff_d  = cfg_holdoff;
          total_d    = cfg_total;
          hold_cnt_d = '0;
          beat_cnt_d = '0;
          overrun_d  = 1'b0;
          state_d    = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == holdoff_q) begin
          prev_vld_d = 1'b0;
          state_d    = ST_WAIT;
        end else if (s_axis_tvalid) begin
          hold_cnt_d = hold_nxt_c;
          if (hold_nxt_c == holdoff_q) begin
            prev_vld_d = 1'b0;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (s_axis_tvalid) begin
          prev_d     = cur_c;
          prev_vld_d = 1'b1;
          if (trig_c) begin
            tdata_d    = s_axis_tdata;
            tvalid_d   = 1'b1;
            beat_cnt_d = beat_nxt_c;
            tlast_d    = (beat_nxt_c == total_q);
            state_d    = (beat_nxt_c == total_q) ? ST_FLUSH : ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (s_axis_tvalid) begin
          if (out_free_c) begin
            tdata_d    = s_axis_tdata;
            tvalid_d   = 1'b1;
            beat_cnt_d = beat_nxt_c;
            tlast_d    = (beat_nxt_c == total_q);
            if (beat_nxt_c == total_q) begin
              state_d = ST_FLUSH;
            end
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (tvalid_q && m_axis_tready && tlast_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      chan_q     <= 1'b0;
      edge_q     <= 1'b0;
      level_q    <= '0;
      holdoff_q  <= '0;
      total_q    <= '0;
      hold_cnt_q <= '0;
      beat_cnt_q <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      edge_q     <= edge_d;
      level_q    <= level_d;
      holdoff_q  <= holdoff_d;
      total_q    <= total_d;
      hold_cnt_q <= hold_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign sts_state     = state_q;
  assign sts_overrun   = overrun_q;

endmodule
